// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: LSU-to-DTCM SRAM controller with 1-cycle read latency and an in-order response buffer.
// `DTCM_CTRL_BACK2BACK_EN selects one command per cycle and a 2-entry buffer; otherwise 1 outstanding, depth 1.
`ifndef DTCM_RAM_AW
`define DTCM_RAM_AW 12
`endif
`ifndef XLEN
`define XLEN 32
`endif

module dtcm_ctrl #(
  parameter int AW = `DTCM_RAM_AW,
  parameter int DW = `XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dtcm_cmd_valid,
  output logic            dtcm_cmd_ready,
  input  logic            dtcm_cmd_read,
  input  logic [AW-1:0]   dtcm_cmd_addr,
  input  logic [DW-1:0]   dtcm_cmd_wdata,
  input  logic [DW/8-1:0] dtcm_cmd_wmask,
  output logic            dtcm_rsp_valid,
  input  logic            dtcm_rsp_ready,
  output logic [DW-1:0]   dtcm_rsp_rdata,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW/8-1:0] ram_wem,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

`ifdef DTCM_CTRL_BACK2BACK_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          inflight;
  logic          inflight_read;
  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [DW-1:0] buf_data [2];
  logic          buf_read [2];

  logic buf_empty;
  logic cmd_fire;
  logic push;
  logic pop;

  assign buf_empty = (count == 2'd0);
  assign cmd_fire  = dtcm_cmd_valid & dtcm_cmd_ready;

`ifdef DTCM_CTRL_BACK2BACK_EN
  assign dtcm_cmd_ready = !rst && ((count + {1'b0, inflight}) < 2'd2);
`else
  assign dtcm_cmd_ready = !rst && buf_empty && !inflight;
`endif

  assign ram_cs   = cmd_fire;
  assign ram_we   = cmd_fire & ~dtcm_cmd_read;
  assign ram_addr = dtcm_cmd_addr;
  assign ram_din  = dtcm_cmd_wdata;
  assign ram_wem  = ram_we ? dtcm_cmd_wmask : '0;

  // Empty buffer bypasses the SRAM output straight to the LSU; otherwise the head entry is shown.
  assign dtcm_rsp_valid = !buf_empty || inflight;
  assign dtcm_rsp_rdata = !buf_empty ? (buf_read[rd_ptr] ? buf_data[rd_ptr] : '0)
                                     : (inflight_read ? ram_dout : '0);

  assign pop  = dtcm_rsp_ready & !buf_empty;
  assign push = inflight & !(buf_empty & dtcm_rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_read <= 1'b0;
      count         <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
    end else begin
      inflight      <= cmd_fire;
      inflight_read <= cmd_fire & dtcm_cmd_read;
      if (push) wr_ptr <= (DEPTH == 2) ? ~wr_ptr : 1'b0;
      if (pop)  rd_ptr <= (DEPTH == 2) ? ~rd_ptr : 1'b0;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Raw SRAM word is captured here so later ram_dout changes cannot disturb a held response.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_data[wr_ptr] <= ram_dout;
      buf_read[wr_ptr] <= inflight_read;
    end
  end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Bench for dtcm_ctrl: SRAM model with garbage dout on idle cycles, queue-based response scoreboard.
module tb_dtcm_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = DW / 8;
`ifdef DTCM_CTRL_BACK2BACK_EN
  localparam int MAX_OUT = 2;
`else
  localparam int MAX_OUT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          dtcm_cmd_valid;
  logic          dtcm_cmd_ready;
  logic          dtcm_cmd_read;
  logic [AW-1:0] dtcm_cmd_addr;
  logic [DW-1:0] dtcm_cmd_wdata;
  logic [MW-1:0] dtcm_cmd_wmask;
  logic          dtcm_rsp_valid;
  logic          dtcm_rsp_ready;
  logic [DW-1:0] dtcm_rsp_rdata;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  dtcm_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready),
    .dtcm_cmd_read(dtcm_cmd_read), .dtcm_cmd_addr(dtcm_cmd_addr),
    .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready),
    .dtcm_rsp_rdata(dtcm_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    return {8'hA5, 8'(i), 8'(~i), 8'(i * 7)};
  endfunction

  // SRAM model: one-cycle read latency, random dout whenever no read was issued.
  logic [DW-1:0] mem [256];
  logic          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (ram_cs && ram_we) begin
      for (int b = 0; b < MW; b++)
        if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    if (ram_cs && !ram_we) ram_dout <= mem[ram_addr];
    else                   ram_dout <= $urandom;
  end

  // Reference: a response is owed for every accepted command until the LSU takes it.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] rsp_q [$];
  logic          exp_ready;
  logic          exp_valid;
  logic [DW-1:0] exp_rdata;
  int            checks = 0;
  int            errors = 0;

  task automatic predict();
    exp_ready = !rst && (rsp_q.size() < MAX_OUT);
    exp_valid = (rsp_q.size() != 0);
    exp_rdata = exp_valid ? rsp_q[0] : '0;
  endtask

  task automatic advance();
    logic acc, pop, rd;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    predict();
    acc = dtcm_cmd_valid && exp_ready;
    pop = exp_valid && dtcm_rsp_ready;
    rd = dtcm_cmd_read; a = dtcm_cmd_addr; wd = dtcm_cmd_wdata; wm = dtcm_cmd_wmask;
    @(posedge clk);
    if (rst) begin
      rsp_q.delete();
    end else begin
      if (pop) void'(rsp_q.pop_front());
      if (acc) begin
        if (rd) begin
          rsp_q.push_back(ref_mem[a]);
        end else begin
          for (int b = 0; b < MW; b++)
            if (wm[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
          rsp_q.push_back('0);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm, input logic rr);
    dtcm_cmd_valid = v; dtcm_cmd_read = rd; dtcm_cmd_addr = a;
    dtcm_cmd_wdata = wd; dtcm_cmd_wmask = wm; dtcm_rsp_ready = rr;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
      #1;
      advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'h3, '0, '0, 1'b1);
    #1;
    checks++; if (dtcm_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b exp 0", dtcm_cmd_ready); end
    checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL reset_cs_low: got %b exp 0", ram_cs); end
    advance();
    rst = 1'b0;
    drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
    #1;
    checks++; if (dtcm_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b exp 1", dtcm_cmd_ready); end
    checks++; if (dtcm_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", dtcm_rsp_valid); end
    advance();
  endtask

  task automatic test_single_read();
    idle(2);
    drive(1'b1, 1'b0, 8'h05, 32'hDEADBEEF, 4'hF, 1'b1);
    #1; advance();
    idle(2);
    drive(1'b1, 1'b1, 8'h05, '0, '0, 1'b1);
    #1;
    checks++; if (dtcm_cmd_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %b exp 1", dtcm_cmd_ready); end
    checks++; if (ram_we !== 1'b0 || ram_wem !== 4'h0) begin errors++; $display("FAIL read_we_wem: got we=%b wem=%h exp 0/0", ram_we, ram_wem); end
    advance();
    drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
    #1;
    checks++; if (dtcm_rsp_valid !== 1'b1) begin errors++; $display("FAIL read_rsp_valid: got %b exp 1", dtcm_rsp_valid); end
    checks++; if (dtcm_rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h exp deadbeef", dtcm_rsp_rdata); end
    advance();
  endtask

  task automatic test_write();
    logic [DW-1:0] w;
    idle(2);
    drive(1'b1, 1'b0, 8'h10, 32'h12345678, 4'b0011, 1'b1);
    #1;
    checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL write_cs_we: got cs=%b we=%b exp 1/1", ram_cs, ram_we); end
    checks++; if (ram_wem !== 4'b0011) begin errors++; $display("FAIL write_wem: got %b exp 0011", ram_wem); end
    checks++; if (ram_addr !== 8'h10 || ram_din !== 32'h12345678) begin errors++; $display("FAIL write_addr_din: got %h/%h exp 10/12345678", ram_addr, ram_din); end
    advance();
    drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
    #1;
    checks++; if (dtcm_rsp_valid !== 1'b1 || dtcm_rsp_rdata !== 32'h0) begin errors++; $display("FAIL write_rsp: got v=%b d=%h exp 1/0", dtcm_rsp_valid, dtcm_rsp_rdata); end
    advance();
    idle(1);
    drive(1'b1, 1'b1, 8'h10, '0, 4'hF, 1'b1);
    #1; advance();
    drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
    w = init_word(16);
    #1;
    checks++; if (dtcm_rsp_rdata !== {w[31:16], 16'h5678}) begin errors++; $display("FAIL write_readback: got %h exp %h", dtcm_rsp_rdata, {w[31:16], 16'h5678}); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic pat_ready, pat_valid;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 8'($urandom_range(0, 255)), '0, '0, 1'b1);
      pat_ready = (MAX_OUT == 2) ? 1'b1 : (i % 2 == 0);
      pat_valid = (MAX_OUT == 2) ? (i >= 1) : (i % 2 == 1);
      #1; predict();
      checks++; if (dtcm_cmd_ready !== pat_ready) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp %b", i, dtcm_cmd_ready, pat_ready); end
      checks++; if (dtcm_rsp_valid !== pat_valid) begin errors++; $display("FAIL b2b_valid[%0d]: got %b exp %b", i, dtcm_rsp_valid, pat_valid); end
      if (pat_valid) begin
        checks++; if (dtcm_rsp_rdata !== exp_rdata) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h exp %h", i, dtcm_rsp_rdata, exp_rdata); end
      end
      advance();
    end
    drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
    #1; predict();
    checks++; if (dtcm_rsp_valid !== exp_valid) begin errors++; $display("FAIL b2b_tail_valid: got %b exp %b", dtcm_rsp_valid, exp_valid); end
    if (exp_valid) begin
      checks++; if (dtcm_rsp_rdata !== exp_rdata) begin errors++; $display("FAIL b2b_tail_rdata: got %h exp %h", dtcm_rsp_rdata, exp_rdata); end
    end
    advance();
  endtask

  task automatic test_stall();
    int n_acc;
    logic [DW-1:0] held;
    n_acc = 0; held = '0;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'($urandom_range(0, 255)), '0, '0, 1'b0);
      #1; predict();
      if (ram_cs === 1'b1) n_acc++;
      if (i == 3) begin
        checks++; if (dtcm_cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b exp 0", dtcm_cmd_ready); end
      end
      if (i >= 1) begin
        checks++; if (dtcm_rsp_valid !== 1'b1 || dtcm_rsp_rdata !== exp_rdata) begin errors++; $display("FAIL stall_head[%0d]: got v=%b d=%h exp 1/%h", i, dtcm_rsp_valid, dtcm_rsp_rdata, exp_rdata); end
        if (i == 1) held = dtcm_rsp_rdata;
        else begin
          checks++; if (dtcm_rsp_rdata !== held) begin errors++; $display("FAIL stall_hold[%0d]: got %h exp %h", i, dtcm_rsp_rdata, held); end
        end
      end
      advance();
    end
    checks++; if (n_acc != MAX_OUT) begin errors++; $display("FAIL stall_accepts: got %0d exp %0d", n_acc, MAX_OUT); end
    for (int k = 0; k < 6 && rsp_q.size() != 0; k++) begin
      drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
      #1; predict();
      checks++; if (dtcm_rsp_valid !== 1'b1 || dtcm_rsp_rdata !== exp_rdata) begin errors++; $display("FAIL stall_drain[%0d]: got v=%b d=%h exp 1/%h", k, dtcm_rsp_valid, dtcm_rsp_rdata, exp_rdata); end
      advance();
    end
    drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
    #1;
    checks++; if (dtcm_cmd_ready !== 1'b1 || dtcm_rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_recover: got rdy=%b v=%b exp 1/0", dtcm_cmd_ready, dtcm_rsp_valid); end
    advance();
  endtask

  task automatic test_reset_mid();
    idle(2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'($urandom_range(0, 255)), '0, '0, 1'b0);
      #1; advance();
    end
    drive(1'b0, 1'b1, '0, '0, '0, 1'b0);
    #1; advance();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'h1, '0, '0, 1'b0);
    #1;
    checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL rstmid_cs: got %b exp 0", ram_cs); end
    advance();
    rst = 1'b0;
    drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
    #1;
    checks++; if (dtcm_rsp_valid !== 1'b0 || dtcm_cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after: got v=%b rdy=%b exp 0/1", dtcm_rsp_valid, dtcm_cmd_ready); end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
      #1;
      checks++; if (dtcm_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: got %b exp 0", k, dtcm_rsp_valid); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1), 8'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
      #1; predict();
      checks++; if (dtcm_cmd_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b exp %b", i, dtcm_cmd_ready, exp_ready); end
      checks++; if (ram_cs !== (dtcm_cmd_valid && exp_ready)) begin errors++; $display("FAIL rand_cs[%0d]: got %b exp %b", i, ram_cs, dtcm_cmd_valid && exp_ready); end
      checks++; if (dtcm_rsp_valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b exp %b", i, dtcm_rsp_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (dtcm_rsp_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h exp %h", i, dtcm_rsp_rdata, exp_rdata); end
      end
      if (dtcm_cmd_read) begin
        checks++; if (ram_wem !== 4'h0) begin errors++; $display("FAIL rand_read_wem[%0d]: got %h exp 0", i, ram_wem); end
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b1;
    drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion exp finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/dtcm_ctrl.md
DTCM_CTRL -- requirements
Module: dtcm_ctrl

Interface
REQ-001 Parameter AW, default `DTCM_RAM_AW, word-address width of the command and the RAM.
REQ-002 Parameter DW, default `XLEN, data width; the mask width is DW/8.
REQ-003 Reset and clock: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 dtcm_cmd_valid  in  1  LSU command valid.
REQ-007 dtcm_cmd_ready  out  1  controller accepts a command.
REQ-008 dtcm_cmd_read  in  1  1=read, 0=write.
REQ-009 dtcm_cmd_addr  in  AW  word address.
REQ-010 dtcm_cmd_wdata  in  DW  write data.
REQ-011 dtcm_cmd_wmask  in  DW/8  byte write enables.
REQ-012 dtcm_rsp_valid  out  1  response valid.
REQ-013 dtcm_rsp_ready  in  1  LSU accepts the response.
REQ-014 dtcm_rsp_rdata  out  DW  read data; 0 for write responses.
REQ-015 ram_cs  out  1  SRAM chip select.
REQ-016 ram_we  out  1  SRAM write enable.
REQ-017 ram_addr  out  AW  SRAM address.
REQ-018 ram_wem  out  DW/8  SRAM byte enables.
REQ-019 ram_din  out  DW  SRAM write data.
REQ-020 ram_dout  in  DW  SRAM read data, valid one cycle after ram_cs.

Function
REQ-021 A command is accepted in cycle T iff dtcm_cmd_valid & dtcm_cmd_ready.
REQ-022 In the accept cycle only, ram_cs=1; ram_we=~dtcm_cmd_read; ram_addr, ram_din and ram_wem pass the command fields through.
REQ-023 ram_wem SHALL be 0 for reads.
REQ-024 Every accepted command (read or write) produces exactly one response, in acceptance order.
REQ-025 An inflight flag SHALL be set at T+1 for a command accepted at T, and cleared otherwise.
REQ-026 A 2-entry response buffer stores {is_read, data} with a 2-bit count and wrap-around read/write pointers.
REQ-027 When the buffer is empty and inflight=1, rsp_valid=1 and rsp_rdata = is_read ? ram_dout : 0, giving 1-cycle latency.
REQ-028 If that bypassed response is not accepted, it is pushed into the buffer at the end of the cycle.
REQ-029 When the buffer is non-empty, the head entry is presented, and any inflight response is pushed behind it.
REQ-030 Push and pop in the same cycle leave the count unchanged and preserve order.
REQ-031 rsp_valid is held and rsp_rdata stays stable until rsp_ready; ram_dout changes SHALL NOT affect buffered data.
REQ-032 dtcm_cmd_ready = (count + inflight) < 2, combinational and independent of dtcm_cmd_valid; the buffer can never overflow.

Reset
REQ-033 Reset clears inflight, count and pointers; rsp_valid=0 and dtcm_cmd_ready=1 in the cycle after reset.
REQ-034 Reset mid-operation discards the inflight response and all buffered responses.
REQ-035 While rst=1, dtcm_cmd_ready=0 and ram_cs=0.

Configuration
REQ-036 With macro DTCM_CTRL_BACK2BACK_EN defined, the behaviour is as REQ-032: full throughput of one command per cycle while rsp_ready=1.
REQ-037 With DTCM_CTRL_BACK2BACK_EN undefined, dtcm_cmd_ready = (count==0) & ~inflight, allowing one outstanding command at a maximum rate of one every 2 cycles.
REQ-038 With DTCM_CTRL_BACK2BACK_EN undefined, the buffer depth SHALL reduce to 1.

Verification
REQ-039 Single read, where ram_dout returns 0xDEADBEEF at T+1 and rsp_ready=1 -> rsp_valid=1 at T+1 with rdata=0xDEADBEEF.
REQ-040 Write addr 0x10, wdata 0x12345678, wmask 0b0011 -> ram_we=1 and ram_wem=0b0011 at T; response at T+1 with rdata=0.
REQ-041 Back-to-back reads A,B,C (B2B_EN) with rsp_ready=1 -> cmd_ready stays 1 and responses arrive at T+1, T+2, T+3 in order.
REQ-042 rsp_ready=0 for 4 cycles during reads (B2B_EN) -> exactly 2 accepted, cmd_ready=0 afterwards, data held; after release, both responses drain in order and cmd_ready returns to 1.
REQ-043 rst asserted with count=2 -> next cycle rsp_valid=0, cmd_ready=1, and no stale response appears.
REQ-044 With B2B_EN undefined, continuous valid reads -> cmd_ready alternates 1,0 and one response every 2 cycles.
